// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing controller: Moore FSM stepping the shared datapath
// one instruction phase per state, with a memory-ready handshake and sticky HALT.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       Retire,
  output logic       Halted
);

  // MemReady handshake: in FETCH/MEMREAD/MEMWRITE the FSM holds its outputs
  // until MemReady=1 in the same cycle; that cycle completes the access.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_e     state_q, state_d;
  state_e     cur_s;
  logic       alu_f3_ok;
  logic       br_f3_ok;
  logic [2:0] exec_alu;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
    br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
    case (funct3)
      3'b000:  exec_alu = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  exec_alu = 3'b101;
      3'b110:  exec_alu = 3'b011;
      3'b111:  exec_alu = 3'b010;
      default: exec_alu = 3'b000;
    endcase
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // While reset is held the outputs show FETCH regardless of the stored state.
  always_comb begin
    cur_s      = reset ? state_q : S_FETCH;
    state_d    = cur_s;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    Retire     = 1'b0;
    Halted     = 1'b0;
    case (cur_s)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady & reset;
        PCWrite   = MemReady & reset;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = alu_f3_ok ? S_EXECR : S_HALT;
          OP_I:         state_d = alu_f3_ok ? S_EXECI : S_HALT;
          OP_BR:        state_d = br_f3_ok ? S_BRANCH : S_HALT;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = MemReady;
        state_d  = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = exec_alu;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = exec_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = Zero ^ funct3[0];
        Retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected output bundles are queued
// as each cycle is driven and compared at the following falling edge.
module tb_multicycle_controller;

  localparam logic [3:0] P_F  = 4'd0;
  localparam logic [3:0] P_D  = 4'd1;
  localparam logic [3:0] P_MA = 4'd2;
  localparam logic [3:0] P_MR = 4'd3;
  localparam logic [3:0] P_MB = 4'd4;
  localparam logic [3:0] P_MW = 4'd5;
  localparam logic [3:0] P_ER = 4'd6;
  localparam logic [3:0] P_EI = 4'd7;
  localparam logic [3:0] P_AW = 4'd8;
  localparam logic [3:0] P_BR = 4'd9;
  localparam logic [3:0] P_J  = 4'd10;
  localparam logic [3:0] P_H  = 4'd11;

  typedef struct {
    string           name;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic            zero;
    logic [2:0]      alu_x;
    logic            bpc;
    logic [1:0]      imm;
    logic [5:0][3:0] seq;
    int              n;
    int              fstall;
    int              mstall;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  logic [17:0] exp_q[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  int          ret_exp = 0;
  int          ret_seen = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Retire(Retire), .Halted(Halted)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (Retire === 1'b1) ret_seen++;

  function automatic logic [17:0] exp_out(input logic [3:0] ph, input vec_t v, input logic mr);
    logic pcw, adr, mw, irw, rw, ret, hlt;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ret = 0; hlt = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (ph)
      P_F:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      P_D:  begin sa = 2'b01; sb = 2'b01; end
      P_MA: begin sa = 2'b10; sb = 2'b01; end
      P_MR: adr = 1;
      P_MB: begin rs = 2'b01; rw = 1; ret = 1; end
      P_MW: begin adr = 1; mw = 1; ret = mr; end
      P_ER: begin sa = 2'b10; sb = 2'b00; alu = v.alu_x; end
      P_EI: begin sa = 2'b10; sb = 2'b01; alu = v.alu_x; end
      P_AW: begin rw = 1; ret = 1; end
      P_BR: begin sa = 2'b10; alu = 3'b001; pcw = v.bpc; ret = 1; end
      P_J:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      P_H:  hlt = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, v.imm, ret, hlt};
  endfunction

  // scoreboard
  task automatic check(input string tag);
    logic [17:0] got, exp;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, Retire, Halted};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b required %b", tag, $time, got, exp);
    end
  endtask

  // driver: one clock cycle in a given phase
  task automatic cyc(input logic [3:0] ph, input vec_t v, input logic mr, input logic rst);
    logic [17:0] e;
    @(posedge clk); #1;
    reset = rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.zero; MemReady = mr;
    e = exp_out(rst ? ph : P_F, v, rst ? mr : 1'b0);
    exp_q.push_back(e);
    if (e[1]) ret_exp++;
    @(negedge clk);
    check(v.name);
  endtask

  task automatic run_instr(input vec_t v);
    int st;
    for (int i = 0; i < v.n; i++) begin
      st = (v.seq[i] == P_F) ? v.fstall :
           (v.seq[i] == P_MR || v.seq[i] == P_MW) ? v.mstall : 0;
      for (int s = 0; s <= st; s++) cyc(v.seq[i], v, (s == st), 1'b1);
    end
  endtask

  task automatic add_vec(input string name, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z, input logic [2:0] ax, input logic bp,
                         input logic [1:0] im, input logic [3:0] p0, input logic [3:0] p1,
                         input logic [3:0] p2, input logic [3:0] p3, input logic [3:0] p4,
                         input int n, input int fs, input int ms);
    vec_t v;
    v.name = name; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.alu_x = ax; v.bpc = bp;
    v.imm = im; v.seq[0] = p0; v.seq[1] = p1; v.seq[2] = p2; v.seq[3] = p3; v.seq[4] = p4;
    v.seq[5] = P_F; v.n = n; v.fstall = fs; v.mstall = ms;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t h;
    reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    Zero = 1'b0; MemReady = 1'b1;

    //      name     op          f3    f7 z  alu   bp im     seq                     n fs ms
    add_vec("add",   7'b0110011, 3'b000, 0, 0, 3'b000, 0, 2'b00, P_F, P_D, P_ER, P_AW, P_F, 4, 0, 0);
    add_vec("sub",   7'b0110011, 3'b000, 1, 0, 3'b001, 0, 2'b00, P_F, P_D, P_ER, P_AW, P_F, 4, 0, 0);
    add_vec("slt",   7'b0110011, 3'b010, 0, 1, 3'b101, 0, 2'b00, P_F, P_D, P_ER, P_AW, P_F, 4, 0, 0);
    add_vec("or",    7'b0110011, 3'b110, 0, 0, 3'b011, 0, 2'b00, P_F, P_D, P_ER, P_AW, P_F, 4, 0, 0);
    add_vec("and",   7'b0110011, 3'b111, 0, 0, 3'b010, 0, 2'b00, P_F, P_D, P_ER, P_AW, P_F, 4, 0, 0);
    add_vec("addi",  7'b0010011, 3'b000, 1, 0, 3'b000, 0, 2'b00, P_F, P_D, P_EI, P_AW, P_F, 4, 2, 0);
    add_vec("andi",  7'b0010011, 3'b111, 0, 0, 3'b010, 0, 2'b00, P_F, P_D, P_EI, P_AW, P_F, 4, 0, 0);
    add_vec("lw",    7'b0000011, 3'b010, 0, 0, 3'b000, 0, 2'b00, P_F, P_D, P_MA, P_MR, P_MB, 5, 0, 0);
    add_vec("sw",    7'b0100011, 3'b010, 0, 0, 3'b000, 0, 2'b01, P_F, P_D, P_MA, P_MW, P_F, 4, 0, 0);
    add_vec("beq_z1",7'b1100011, 3'b000, 0, 1, 3'b000, 1, 2'b10, P_F, P_D, P_BR, P_F, P_F, 3, 0, 0);
    add_vec("beq_z0",7'b1100011, 3'b000, 0, 0, 3'b000, 0, 2'b10, P_F, P_D, P_BR, P_F, P_F, 3, 0, 0);
    add_vec("bne_z1",7'b1100011, 3'b001, 0, 1, 3'b000, 0, 2'b10, P_F, P_D, P_BR, P_F, P_F, 3, 0, 0);
    add_vec("bne_z0",7'b1100011, 3'b001, 0, 0, 3'b000, 1, 2'b10, P_F, P_D, P_BR, P_F, P_F, 3, 0, 0);
    add_vec("jal",   7'b1101111, 3'b000, 0, 0, 3'b000, 0, 2'b11, P_F, P_D, P_J,  P_AW, P_F, 4, 0, 0);
    add_vec("lw_st", 7'b0000011, 3'b010, 0, 0, 3'b000, 0, 2'b00, P_F, P_D, P_MA, P_MR, P_MB, 5, 0, 3);
    add_vec("sw_st", 7'b0100011, 3'b010, 0, 0, 3'b000, 0, 2'b01, P_F, P_D, P_MA, P_MW, P_F, 4, 1, 2);

    // reset held two cycles with MemReady=1: FETCH decode, IR/PC strobes gated
    cyc(P_F, tbl[0], 1'b1, 1'b0);
    cyc(P_F, tbl[0], 1'b1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) run_instr(tbl[i]);

    // illegal opcode: sticky HALT for 10 cycles, then reset recovers to FETCH
    h = tbl[0]; h.name = "halt_sys"; h.op = 7'b1110011; h.imm = 2'b00;
    cyc(P_F, h, 1'b1, 1'b1);
    cyc(P_D, h, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc(P_H, h, ($urandom_range(0, 1) == 1), 1'b1);
    cyc(P_F, h, 1'b1, 1'b0);
    run_instr(tbl[1]);

    // unsupported R-type funct3 and unsupported branch funct3 both halt
    h = tbl[0]; h.name = "halt_sll"; h.f3 = 3'b001;
    cyc(P_F, h, 1'b1, 1'b1);
    cyc(P_D, h, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(P_H, h, 1'b1, 1'b1);
    cyc(P_F, h, 1'b1, 1'b0);
    h = tbl[9]; h.name = "halt_blt"; h.f3 = 3'b100;
    cyc(P_F, h, 1'b1, 1'b1);
    cyc(P_D, h, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(P_H, h, 1'b1, 1'b1);
    cyc(P_F, h, 1'b1, 1'b0);

    // reset asserted mid-wait in MEMREAD aborts the load
    h = tbl[7]; h.name = "rst_mr";
    cyc(P_F,  h, 1'b1, 1'b1);
    cyc(P_D,  h, 1'b1, 1'b1);
    cyc(P_MA, h, 1'b1, 1'b1);
    cyc(P_MR, h, 1'b0, 1'b1);
    cyc(P_MR, h, 1'b0, 1'b1);
    cyc(P_F,  h, 1'b0, 1'b0);
    run_instr(tbl[13]);

    // reset asserted mid-wait in MEMWRITE
    h = tbl[8]; h.name = "rst_mw";
    cyc(P_F,  h, 1'b1, 1'b1);
    cyc(P_D,  h, 1'b1, 1'b1);
    cyc(P_MA, h, 1'b1, 1'b1);
    cyc(P_MW, h, 1'b0, 1'b1);
    cyc(P_F,  h, 1'b1, 1'b0);
    run_instr(tbl[0]);

    @(posedge clk); #1;
    checks++;
    if (ret_seen != ret_exp) begin
      errors++;
      $display("FAIL retire_count got %0d required %0d", ret_seen, ret_exp);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle variant of the RV32I core: a Moore FSM plus combinational ALU/immediate decoders that drive the shared-ALU, shared-memory datapath one instruction phase per state. Supports lw, sw, R-type, I-type ALU, beq/bne and jal. Adds a memory-ready handshake and a sticky halt on illegal encodings. Sits beside the datapath in place of the single-cycle controller; the datapath holds PC, OldPC, IR, Data, A/B and ALUOut registers.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on rising clk edge
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  load PC from Result
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR and OldPC
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  out  2  00=B, 01=ImmExt, 10=constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- Retire  out  1  one-cycle pulse on the final cycle of every instruction
- Halted  out  1  FSM is in HALT

## Operation
- State register 4 bits: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT. All outputs are decoded from state (plus op/funct3/funct7b5/Zero/MemReady where stated); unlisted outputs are 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=MemReady. MemReady=1 -> DECODE, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. Next by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other -> HALT. Also -> HALT if decoded ALU op is unsupported (funct3 not in {000,010,110,111} for R/I; branch funct3 not in {000,001}).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. op[5]=0 -> MEMREAD, 1 -> MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. MemReady -> MEMWB, else stay.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1 -> FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 (held every waiting cycle). MemReady -> FETCH with Retire=1, else stay.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode -> ALUWB. EXECI: ALUSrcB=01, otherwise same -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite = Zero XOR funct3[0]; Retire=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
- HALT: all strobes 0, Halted=1; exit only via reset.
- ALU decode (EXECR/EXECI): funct3 000 -> sub if op[5]&funct7b5 else add; 010 slt; 110 or; 111 and. ImmSrc from op alone: lw/I 00, sw 01, branch 10, jal 11, else 00.

## Timing
- reset=0 at a rising edge: state<=FETCH next cycle; holds priority over every transition including mid-wait in MEMREAD/MEMWRITE and HALT. During reset and the first cycle after, outputs are the FETCH decode; IRWrite/PCWrite gated by MemReady only after reset deasserts.
- Instruction cycle counts with MemReady tied 1: lw 5, sw 4, R/I 4, branch 3, jal 4. Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle; no upper bound.
- Retire asserts exactly once per completed instruction; never in HALT.
- MemWrite is never asserted outside MEMWRITE; RegWrite never together with MemWrite.

## Test plan
- Reset: reset=0 two cycles with MemReady=1 -> state FETCH, Halted=0, Retire=0, MemWrite=0, RegWrite=0; first post-reset edge loads IR (IRWrite=1).
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MemReady=1 -> FETCH,DECODE,EXECR(ALUControl 000),ALUWB(RegWrite=1,Retire=1); 4 cycles; f7b5=1 gives 001.
- lw with MemReady low 3 cycles in MEMREAD -> stays MEMREAD 4 cycles, AdrSrc=1 throughout, then MEMWB RegWrite=1, ResultSrc=01; 8 cycles total.
- sw with MemReady low 2 cycles -> MemWrite=1 for 3 consecutive cycles, Retire on the ready cycle, no RegWrite.
- beq Zero=1 -> PCWrite=1 in BRANCH; bne (f3 001) Zero=1 -> PCWrite=0; jal -> PCWrite in JAL, RegWrite in ALUWB, 4 cycles.
- op 1110011 in DECODE -> HALT, Halted=1 held 10 cycles with no strobes; reset=0 mid-HALT -> FETCH.
